// File: rtl/iodev_gen.sv
// Parameterised 68000-bus I/O device: ADC front end, digital in/out, DTACK wait states.
// The watchdog counter is built only when IODEV_WDT_EN is defined; otherwise wdt_rst is tied low.
module iodev_gen #(
    parameter int NCH      = 4,
    parameter int DIN_W    = 8,
    parameter int DOUT_W   = 8,
    parameter int CONV_CYC = 32,
    parameter int WAIT_CYC = 0,
    parameter int WDT_CYC  = 262144
) (
    input  logic              cl,
    input  logic              reset,
    input  logic [22:0]       ad,
    input  logic              as,
    input  logic              rw,
    input  logic              uds,
    input  logic              lds,
    input  logic [15:0]       od,
    output logic              dtack,
    output logic              dv,
    output logic [15:0]       id,
    input  logic [NCH*8-1:0]  adc_in,
    input  logic [DIN_W-1:0]  din,
    output logic [DOUT_W-1:0] dout,
    output logic              wdt_rst
);
    localparam int CHB = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;
    localparam logic [TW-1:0]  TMR_INIT = TW'(CONV_CYC - 1);
    localparam logic [3:0]     WAIT_L   = 4'(WAIT_CYC);
    localparam logic [CHB:0]   NCH_L    = (CHB + 1)'(NCH);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    logic [2:0] sub;
    logic       hit, sel_adc, sel_start, sel_io, sel_wdt;
    logic       axs, start, wr, busy, ch_ok;
    logic [CHB:0] ch_ext;

    assign sub       = ad[15:13];
    assign hit       = (ad[22:17] == 6'b100101);
    assign sel_adc   = hit & (sub == 3'b000);
    assign sel_start = hit & (sub == 3'b001);
    assign sel_io    = hit & (sub == 3'b010);
    assign sel_wdt   = hit & (sub == 3'b110);
    assign axs       = as & (sel_adc | sel_start | sel_io | sel_wdt) & (uds | lds);

    logic                axs_q, dtack_q, dtack_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DIN_W-1:0]    sync1_q, sync2_q, din_q, din_d;
    logic [DOUT_W-1:0]   dout_q, dout_d;
    state_t              state_q;
    logic [CHB-1:0]      ch_q;
    logic [TW-1:0]       timer_q;
    logic [7:0]          result_q;

    assign start  = axs & ~axs_q;
    assign wr     = start & rw & lds;
    assign busy   = (state_q == S_CONV);
    assign ch_ext = {1'b0, ad[CHB-1:0]};
    assign ch_ok  = (ch_ext < NCH_L);

    always_comb begin
        cnt_d = '0;
        if (axs)
            cnt_d = (cnt_q == WAIT_L) ? cnt_q : cnt_q + 4'd1;
        dtack_d = axs & (cnt_q == WAIT_L);
        din_d   = (start & ~rw & sel_io) ? sync2_q : din_q;
        dout_d  = (wr & sel_io) ? od[DOUT_W-1:0] : dout_q;
    end

    always_ff @(posedge cl or posedge reset) begin
        if (reset) begin
            axs_q   <= 1'b0;
            cnt_q   <= '0;
            dtack_q <= 1'b0;
            sync1_q <= '1;
            sync2_q <= '1;
            din_q   <= '1;
            dout_q  <= '0;
        end else begin
            axs_q   <= axs;
            cnt_q   <= cnt_d;
            dtack_q <= dtack_d;
            sync1_q <= din;
            sync2_q <= sync1_q;
            din_q   <= din_d;
            dout_q  <= dout_d;
        end
    end

    // Start writes while converting are dropped, so busy is never extended.
    always_ff @(posedge cl or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            timer_q  <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (wr & sel_start) begin
                    ch_q    <= ch_ok ? ad[CHB-1:0] : '0;
                    timer_q <= TMR_INIT;
                    state_q <= S_CONV;
                end
                S_CONV: if (timer_q == '0) begin
                    result_q <= adc_in[{ch_q, 3'b000} +: 8];
                    state_q  <= S_IDLE;
                end else begin
                    timer_q <= timer_q - TW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [15:0] din_ext;
    always_comb begin
        din_ext = '1;
        din_ext[DIN_W-1:0] = din_q;
        id = 16'hFFFF;
        if (axs & ~rw) begin
            if (sel_adc)
                id = {busy, 7'h00, result_q};
            else if (sel_io)
                id = din_ext;
        end
    end

    assign dtack = dtack_q;
    assign dv    = axs & ~rw;
    assign dout  = dout_q;

`ifdef IODEV_WDT_EN
    localparam int WW = $clog2(WDT_CYC + 1);
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [3:0]    pls_q, pls_d;
    logic          wdt_q, wdt_d, kick;

    assign kick = wr & sel_wdt;

    // A kick resets the count but never cuts a pulse short.
    always_comb begin
        wcnt_d = kick ? '0 : wcnt_q + WW'(1);
        pls_d  = pls_q;
        wdt_d  = wdt_q;
        if (wdt_q) begin
            if (pls_q == 4'd0) begin
                wdt_d  = 1'b0;
                wcnt_d = '0;
            end else begin
                pls_d = pls_q - 4'd1;
            end
        end else if (wcnt_d == WW'(WDT_CYC - 1)) begin
            wdt_d = 1'b1;
            pls_d = 4'd15;
        end
    end

    always_ff @(posedge cl or posedge reset) begin
        if (reset) begin
            wcnt_q <= '0;
            pls_q  <= '0;
            wdt_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            pls_q  <= pls_d;
            wdt_q  <= wdt_d;
        end
    end

    assign wdt_rst = wdt_q;
`else
    assign wdt_rst = 1'b0;
`endif

    logic unused_ad;
    assign unused_ad = ^{ad[16], ad[12:CHB]};
    if (DOUT_W < 16) begin : g_od_unused
        logic unused_od;
        assign unused_od = ^od[15:DOUT_W];
    end
endmodule

// File: tb/tb_iodev_gen.sv
// Directed bench for iodev_gen: scoreboarded bus reads, ADC timing, wait states, reset abort, watchdog.
module tb_iodev_gen;
    logic        cl = 1'b0, reset = 1'b1;
    logic [22:0] ad = '0;
    logic        as = 1'b0, rw = 1'b0, uds = 1'b0, lds = 1'b0;
    logic [15:0] od = '0;
    logic [31:0] adc_in = {8'h44, 8'h7E, 8'h11, 8'h22};
    logic [7:0]  din = 8'h5A;
    logic        dtack, dv, wdt_rst, dtack3, dv3, wdt3;
    logic [15:0] id, id3;
    logic [7:0]  dout, dout3;

    int checks = 0, errors = 0, cyc = 0;
    logic [15:0] exp_q[$];

    iodev_gen #(.NCH(4), .DIN_W(8), .DOUT_W(8), .CONV_CYC(32), .WAIT_CYC(0), .WDT_CYC(100)) u0 (
        .cl(cl), .reset(reset), .ad(ad), .as(as), .rw(rw), .uds(uds), .lds(lds), .od(od),
        .dtack(dtack), .dv(dv), .id(id), .adc_in(adc_in), .din(din), .dout(dout), .wdt_rst(wdt_rst));

    iodev_gen #(.NCH(4), .DIN_W(8), .DOUT_W(8), .CONV_CYC(32), .WAIT_CYC(3), .WDT_CYC(100)) u3 (
        .cl(cl), .reset(reset), .ad(ad), .as(as), .rw(rw), .uds(uds), .lds(lds), .od(od),
        .dtack(dtack3), .dv(dv3), .id(id3), .adc_in(adc_in), .din(din), .dout(dout3), .wdt_rst(wdt3));

    always #5 cl = ~cl;
    always @(posedge cl) cyc <= cyc + 1;

    int wdt_hi = 0;
    always @(negedge cl) if (wdt_rst === 1'b1) wdt_hi <= wdt_hi + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [22:0] addr(input logic [2:0] s, input logic [12:0] lo);
        return {6'b100101, 1'b0, s, lo};
    endfunction

    task automatic bus(input logic [22:0] a, input logic w, input logic u, input logic l,
                       input logic [15:0] d, output logic [15:0] rd, output logic rdv,
                       output int lat, output int t0);
        @(posedge cl); #1;
        ad = a; rw = w; uds = u; lds = l; od = d; as = 1'b1;
        t0 = cyc; lat = -1; rd = 'x; rdv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge cl);
            if (dtack === 1'b1) begin
                lat = cyc - t0; rd = id; rdv = dv;
                break;
            end
        end
        @(posedge cl); #1;
        as = 1'b0; rw = 1'b0; uds = 1'b0; lds = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [22:0] a, input logic [15:0] expv);
        logic [15:0] rd; logic rdv; int lat, t0;
        exp_q.push_back(expv);
        bus(a, 1'b0, 1'b1, 1'b1, 16'h0, rd, rdv, lat, t0);
        chk(tag, rd, exp_q.pop_front());
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_dv"}, rdv, 1'b1);
    endtask

    initial begin
        logic [15:0] rd; logic rdv; int lat, t0, n0, nd, r0, r3, f3, hi, first;
        repeat (3) @(posedge cl);
        @(negedge cl);
        chk("rst_dtack", dtack, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_wdt", wdt_rst, 1'b0);
        chk("rst_id", id, 16'hFFFF);
        chk("rst_dv", dv, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge cl);

        rd_chk("io_rd_5a", addr(3'b010, 13'h0), 16'hFF5A);

        bus(addr(3'b010, 13'h0), 1'b1, 1'b0, 1'b1, 16'h00C3, rd, rdv, lat, t0);
        chk("dout_wr", dout, 8'hC3);
        chk("dout_wr_lat", lat, 1);
        bus(addr(3'b010, 13'h0), 1'b1, 1'b1, 1'b0, 16'h0055, rd, rdv, lat, t0);
        chk("dout_uds_only", dout, 8'hC3);

        din = 8'hA5;
        repeat (3) @(posedge cl);
        rd_chk("io_rd_a5", addr(3'b010, 13'h0), 16'hFFA5);

        rd_chk("adc_rst_res", addr(3'b000, 13'h0), 16'h0000);
        bus(addr(3'b001, 13'h2), 1'b1, 1'b0, 1'b1, 16'h0, rd, rdv, lat, n0);
        chk("adc_start_lat", lat, 1);
        rd_chk("adc_busy", addr(3'b000, 13'h0), 16'h8000);
        bus(addr(3'b001, 13'h1), 1'b1, 1'b0, 1'b1, 16'h0, rd, rdv, lat, t0);
        chk("adc_restart_ack", lat, 1);

        // hold a status read until busy clears
        exp_q.push_back(16'h007E);
        @(posedge cl); #1;
        ad = addr(3'b000, 13'h0); rw = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
        nd = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge cl);
            if (id[15] === 1'b0) begin nd = cyc - n0; rd = id; break; end
        end
        chk("adc_busy_len", nd, 33);
        chk("adc_result", rd, exp_q.pop_front());
        @(posedge cl); #1; as = 1'b0;

        @(posedge cl); #1;
        ad = addr(3'b011, 13'h0); rw = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
        repeat (3) @(negedge cl);
        chk("unmap_dtack", dtack, 1'b0);
        chk("unmap_id", id, 16'hFFFF);
        chk("unmap_dv", dv, 1'b0);
        @(posedge cl); #1; as = 1'b0;

        rd_chk("wdt_rd", addr(3'b110, 13'h0), 16'hFFFF);

        @(posedge cl); #1;
        ad = addr(3'b010, 13'h0); rw = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
        n0 = cyc; r0 = -1; r3 = -1; f3 = -1;
        repeat (10) begin
            @(negedge cl);
            if (dtack === 1'b1 && r0 < 0) r0 = cyc - n0;
            if (dtack3 === 1'b1 && r3 < 0) r3 = cyc - n0;
        end
        @(posedge cl); #1; as = 1'b0; nd = cyc;
        for (int i = 0; i < 10; i++) begin
            @(negedge cl);
            if (dtack3 === 1'b0) begin f3 = cyc - nd; break; end
        end
        chk("wait0_rise", r0, 1);
        chk("wait3_rise", r3, 4);
        chk("wait3_fall", f3, 1);

        bus(addr(3'b001, 13'h3), 1'b1, 1'b0, 1'b1, 16'h0, rd, rdv, lat, t0);
        @(posedge cl); #1;
        ad = addr(3'b000, 13'h0); rw = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
        @(negedge cl);
        chk("conv_busy_pre", id[15], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_id", id, 16'h0000);
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_dtack", dtack, 1'b0);
        @(negedge cl); reset = 1'b0;
        @(posedge cl); #1; as = 1'b0;
        bus(addr(3'b001, 13'h3), 1'b1, 1'b0, 1'b1, 16'h0, rd, rdv, lat, t0);
        repeat (40) @(posedge cl);
        rd_chk("adc_after_rst", addr(3'b000, 13'h0), 16'h0044);

`ifdef IODEV_WDT_EN
        @(negedge cl); reset = 1'b1;
        @(negedge cl); reset = 1'b0; n0 = cyc;
        hi = 0; first = -1;
        for (int i = 0; i < 130; i++) begin
            @(negedge cl);
            if (wdt_rst === 1'b1) begin
                hi++;
                if (first < 0) first = cyc - n0;
            end
        end
        chk("wdt_first", first, 99);
        chk("wdt_len", hi, 16);
        @(negedge cl); reset = 1'b1;
        @(negedge cl); reset = 1'b0;
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            bus(addr(3'b110, 13'h0), 1'b1, 1'b0, 1'b1, 16'h0, rd, rdv, lat, t0);
            for (int i = 0; i < 45; i++) begin
                @(negedge cl);
                if (wdt_rst === 1'b1) hi++;
            end
        end
        chk("wdt_kicked", hi, 0);
`else
        chk("wdt_tied_low", wdt_hi, 0);
`endif
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
